// File: rtl/lif_pkg.sv
// Shared types and constants for the leaky integrate-and-fire neuron array.
// Holds the FSM state encoding, datapath widths and default neuron constants.
package lif_pkg;

  localparam int V_W      = 26;  // membrane potential width
  localparam int BUNDLE_W = 24;  // spike bundle width (max neurons)
  localparam int CUR_W    = 25;  // synaptic current width
  localparam int IDX_W    = 5;   // neuron index width

  localparam logic [V_W-1:0] THRESH_DEF     = 26'd4096;
  localparam int             LEAK_SHIFT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    CLR   = 2'd3
  } state_t;

endpackage

// File: rtl/lif_update.sv
// Single-neuron combinational step: leak, integrate with saturation, fire decision.
// The value to write back is already zeroed when the neuron fires.
module lif_update
  import lif_pkg::*;
#(
  parameter logic [V_W-1:0] THRESH     = THRESH_DEF,
  parameter int             LEAK_SHIFT = LEAK_SHIFT_DEF
) (
  input  logic [V_W-1:0]   i_v,
  input  logic [CUR_W-1:0] i_current,
  input  logic             i_block,
  output logic [V_W-1:0]   o_v_next,
  output logic             o_fire
);

  logic [V_W-1:0]   w_leaked;
  logic [CUR_W-1:0] w_cur;
  logic [V_W:0]     w_sum;
  logic [V_W-1:0]   w_sat;

  // Leak never underflows since V>>LEAK_SHIFT <= V; only the add can overflow.
  assign w_leaked = i_v - (i_v >> LEAK_SHIFT);
  assign w_cur    = i_block ? '0 : i_current;
  assign w_sum    = {1'b0, w_leaked} + {2'b00, w_cur};
  assign w_sat    = w_sum[V_W] ? '1 : w_sum[V_W-1:0];

  assign o_fire   = (w_sat >= THRESH);
  assign o_v_next = o_fire ? '0 : w_sat;

endmodule

// File: rtl/lif_neuron.sv
// Time-multiplexed LIF neuron array: one synapse sample per cycle, spike bundle per timestep.
// Optional per-neuron refractory counters are enabled with the LIF_REFRACTORY_EN macro.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int             N_NEURON   = 18,
  parameter logic [V_W-1:0] THRESH     = THRESH_DEF,
  parameter int             LEAK_SHIFT = LEAK_SHIFT_DEF,
  parameter int             REFRAC     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CUR_W-1:0]    i_current,
  input  logic                i_valid,
  input  logic                i_done,
  input  logic                i_clear,
  output logic [BUNDLE_W-1:0] o_spike_bundle,
  output logic                o_valid,
  output logic                o_busy,
  output logic                o_err
);

  localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N_NEURON);

  if (N_NEURON < 1 || N_NEURON > BUNDLE_W) begin : g_bad_n_neuron
    $error("lif_neuron: N_NEURON must be in 1..24");
  end
  if (REFRAC < 0 || REFRAC > 3) begin : g_bad_refrac
    $error("lif_neuron: REFRAC must fit the 2-bit refractory counter");
  end

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [V_W-1:0]      r_v [N_NEURON];
  logic [BUNDLE_W-1:0] r_spikes;

  logic [V_W-1:0]      w_v_cur;
  logic [V_W-1:0]      w_v_next;
  logic                w_fire;
  logic                w_block;
  logic                w_idx_ok;
  logic                w_accept;
  logic [IDX_W-1:0]    w_idx_after;
  logic [BUNDLE_W-1:0] w_fire_bits;
  logic [BUNDLE_W-1:0] w_spikes_next;

  assign w_idx_ok    = (r_idx < N_IDX);
  // IDLE is only ever entered with idx==0, so its first sample is always in range.
  assign w_accept    = i_valid && ((r_state == IDLE) || ((r_state == ACCUM) && w_idx_ok));
  assign w_idx_after = r_idx + IDX_W'(w_accept);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_v_cur = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      if (r_idx == IDX_W'(i)) w_v_cur = r_v[i];
    end
  end

`ifdef LIF_REFRACTORY_EN
  localparam logic [1:0] REFRAC_LD = 2'(REFRAC);

  logic [1:0] r_refr [N_NEURON];

  always_comb begin
    w_block = 1'b0;
    for (int i = 0; i < N_NEURON; i++) begin
      if (r_idx == IDX_W'(i)) w_block = (r_refr[i] != 2'd0);
    end
  end

  // Load happens at the EMIT of the spiking timestep so the next REFRAC timesteps are blocked.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      for (int i = 0; i < N_NEURON; i++) r_refr[i] <= 2'd0;
    end else if (r_state == EMIT) begin
      for (int i = 0; i < N_NEURON; i++) begin
        if (r_spikes[i])             r_refr[i] <= REFRAC_LD;
        else if (r_refr[i] != 2'd0)  r_refr[i] <= r_refr[i] - 2'd1;
      end
    end
  end
`else
  assign w_block = 1'b0;
`endif

  lif_update #(
    .THRESH     (THRESH),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .i_v       (w_v_cur),
    .i_current (i_current),
    .i_block   (w_block),
    .o_v_next  (w_v_next),
    .o_fire    (w_fire)
  );

  always_comb begin
    w_fire_bits = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      if (r_idx == IDX_W'(i)) w_fire_bits[i] = w_accept && w_fire;
    end
  end

  assign w_spikes_next = r_spikes | w_fire_bits;

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_state        <= reset ? IDLE : CLR;
      r_idx          <= '0;
      r_spikes       <= '0;
      o_spike_bundle <= '0;
      o_valid        <= 1'b0;
      o_busy         <= 1'b0;
      o_err          <= 1'b0;
      // NOTE: the potential array is reset explicitly because a clear must zero every neuron.
      for (int i = 0; i < N_NEURON; i++) r_v[i] <= '0;
    end else begin
      o_valid        <= 1'b0;
      o_spike_bundle <= '0;
      for (int i = 0; i < N_NEURON; i++) begin
        if (w_accept && (r_idx == IDX_W'(i))) r_v[i] <= w_v_next;
      end

      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_state  <= ACCUM;
            r_idx    <= w_idx_after;
            r_spikes <= w_fire_bits;
            o_busy   <= 1'b1;
          end
        end
        ACCUM: begin
          r_idx    <= w_idx_after;
          r_spikes <= w_spikes_next;
          if (i_valid && !w_idx_ok) o_err <= 1'b1;
          if (i_done) begin
            r_state        <= EMIT;
            o_valid        <= 1'b1;
            o_spike_bundle <= w_spikes_next;
            if (w_idx_after != N_IDX) o_err <= 1'b1;
          end
        end
        EMIT: begin
          r_state <= IDLE;
          r_idx   <= '0;
          o_busy  <= 1'b0;
          if (i_valid) o_err <= 1'b1;
        end
        CLR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron; a second instance with THRESH at full scale
// exercises saturation. Refractory checks compile in when LIF_REFRACTORY_EN is defined.
module tb_lif_neuron;
  import lif_pkg::*;

  localparam int N = 18;

  logic                clk = 1'b0;
  logic                reset;
  logic [CUR_W-1:0]    i_current;
  logic                i_valid;
  logic                i_done;
  logic                i_clear;
  logic [BUNDLE_W-1:0] o_bundle_a, o_bundle_b;
  logic                o_valid_a, o_busy_a, o_err_a;
  logic                o_valid_b, o_busy_b, o_err_b;

  logic [CUR_W-1:0]    cur [24];
  logic [BUNDLE_W-1:0] bundle_a, bundle_b;
  logic                pre_valid, valid_seen, valid_b_seen, busy_seen, any_valid;
  int                  n_tests = 0;
  int                  n_fail  = 0;

  always #5 clk = ~clk;

  lif_neuron #(.N_NEURON(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_current      (i_current),
    .i_valid        (i_valid),
    .i_done         (i_done),
    .i_clear        (i_clear),
    .o_spike_bundle (o_bundle_a),
    .o_valid        (o_valid_a),
    .o_busy         (o_busy_a),
    .o_err          (o_err_a)
  );

  lif_neuron #(.N_NEURON(N), .THRESH(26'h3FFFFFF)) dut_sat (
    .clk            (clk),
    .reset          (reset),
    .i_current      (i_current),
    .i_valid        (i_valid),
    .i_done         (i_done),
    .i_clear        (i_clear),
    .o_spike_bundle (o_bundle_b),
    .o_valid        (o_valid_b),
    .o_busy         (o_busy_b),
    .o_err          (o_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_cur();
    for (int k = 0; k < 24; k++) cur[k] = '0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    tick();
  endtask

  // Feeds n samples from cur[], then i_done (merged: on the last sample); captures the EMIT cycle.
  task automatic run_frame(input int n, input bit merged, input bit poke_emit);
    for (int k = 0; k < n; k++) begin
      i_valid   = 1'b1;
      i_current = cur[k];
      i_done    = merged && (k == n - 1);
      if (k == n - 1) pre_valid = o_valid_a;
      tick();
    end
    i_valid   = 1'b0;
    i_current = '0;
    if (!merged) begin
      pre_valid = o_valid_a;
      i_done    = 1'b1;
      tick();
    end
    i_done       = 1'b0;
    valid_seen   = o_valid_a;
    valid_b_seen = o_valid_b;
    busy_seen    = o_busy_a;
    bundle_a     = o_bundle_a;
    bundle_b     = o_bundle_b;
    i_valid      = poke_emit;
    tick();
    i_valid      = 1'b0;
  endtask

  task automatic check_emit(input string tag, input logic [23:0] exp_bundle, input logic exp_err);
    check({tag, " pre-valid"},  pre_valid,   1'b0);
    check({tag, " valid"},      valid_seen,  1'b1);
    check({tag, " bundle"},     bundle_a,    exp_bundle);
    check({tag, " err"},        o_err_a,     exp_err);
    check({tag, " post-valid"}, o_valid_a,   1'b0);
    check({tag, " post-bundle"}, o_bundle_a, 24'h0);
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_done = 1'b0; i_clear = 1'b0; i_current = '0;
    zero_cur();
    tick(); tick();
    check("reset valid",  o_valid_a,  1'b0);
    check("reset busy",   o_busy_a,   1'b0);
    check("reset err",    o_err_a,    1'b0);
    check("reset bundle", o_bundle_a, 24'h0);
    check("reset V0",     dut.r_v[0], 26'd0);
    reset = 1'b0;
    tick();

    // Timestep 1: neuron 0 fires, neuron 1 integrates 4000.
    cur[0] = 25'd5000; cur[1] = 25'd4000;
    run_frame(N, 1'b0, 1'b0);
    check_emit("t1", 24'h000001, 1'b0);
    check("t1 busy in emit", busy_seen, 1'b1);
    check("t1 busy after",   o_busy_a,  1'b0);
    check("t1 V0", dut.r_v[0], 26'd0);
    check("t1 V1", dut.r_v[1], 26'd4000);

    // Timestep 2: leak only on neuron 1; neuron 17 gets a sub-threshold charge.
    zero_cur();
    cur[17] = 25'd1000;
    run_frame(N, 1'b0, 1'b0);
    check_emit("t2", 24'h000000, 1'b0);
    check("t2 V1",  dut.r_v[1],  26'd3500);
    check("t2 V17", dut.r_v[17], 26'd1000);

    // i_done while idle must be ignored.
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    check("idle done valid", o_valid_a, 1'b0);
    check("idle done err",   o_err_a,   1'b0);
    check("idle done busy",  o_busy_a,  1'b0);

    // Short frame: 17 samples; neuron 17 unvisited keeps its potential.
    zero_cur();
    cur[16] = 25'd5000; cur[17] = 25'd5000;
    run_frame(N - 1, 1'b0, 1'b0);
    check_emit("short", 24'h010000, 1'b1);
    check("short V1",  dut.r_v[1],  26'd3063);
    check("short V17", dut.r_v[17], 26'd1000);
    tick(); tick();
    check("short err sticky", o_err_a, 1'b1);
    pulse_clear();
    check("clear err",  o_err_a,     1'b0);
    check("clear V1",   dut.r_v[1],  26'd0);
    check("clear V17",  dut.r_v[17], 26'd0);
    check("clear busy", o_busy_a,    1'b0);

    // Nineteenth sample lands with idx==N and is dropped.
    zero_cur();
    cur[18] = 25'd5000;
    run_frame(N + 1, 1'b0, 1'b0);
    check_emit("overrun", 24'h000000, 1'b1);
    check("overrun V0", dut.r_v[0], 26'd0);
    pulse_clear();

    // i_valid during EMIT is ignored and flags an error.
    zero_cur();
    run_frame(N, 1'b0, 1'b1);
    check_emit("emit poke", 24'h000000, 1'b1);
    pulse_clear();

    // Last sample and i_done in the same cycle.
    zero_cur();
    cur[17] = 25'd5000;
    run_frame(N, 1'b1, 1'b0);
    check_emit("merged", 24'h020000, 1'b0);
    check("merged V17", dut.r_v[17], 26'd0);

    // Saturation on the full-scale-threshold instance.
    pulse_clear();
    zero_cur();
    cur[2] = 25'h1FFFFFF;
    run_frame(N, 1'b0, 1'b0);
    check("sat t1 bundle", bundle_b, 24'h0);
    check("sat t1 V2", dut_sat.r_v[2], 26'h1FFFFFF);
    check("sat main bundle", bundle_a, 24'h000004);
    run_frame(N, 1'b0, 1'b0);
    check("sat t2 bundle", bundle_b, 24'h0);
    check("sat t2 V2", dut_sat.r_v[2], 26'h3BFFFFF);
    run_frame(N, 1'b0, 1'b0);
    check("sat t3 valid",  valid_b_seen, 1'b1);
    check("sat t3 bundle", bundle_b, 24'h000004);
    check("sat t3 V2", dut_sat.r_v[2], 26'h0);

    // Reset mid-frame after nine samples discards the partial timestep.
    zero_cur();
    for (int k = 0; k < 9; k++) cur[k] = 25'd3000;
    for (int k = 0; k < 9; k++) begin
      i_valid = 1'b1; i_current = cur[k];
      tick();
    end
    i_valid = 1'b0; i_current = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    any_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      any_valid = any_valid | o_valid_a;
      tick();
    end
    check("midreset no valid", any_valid, 1'b0);
    check("midreset V0",   dut.r_v[0], 26'd0);
    check("midreset V8",   dut.r_v[8], 26'd0);
    check("midreset busy", o_busy_a,   1'b0);
    zero_cur();
    cur[0] = 25'd5000; cur[1] = 25'd4000;
    run_frame(N, 1'b0, 1'b0);
    check_emit("after reset", 24'h000001, 1'b0);
    check("after reset V1", dut.r_v[1], 26'd4000);

`ifdef LIF_REFRACTORY_EN
    // Neuron 0 fed 5000 every timestep: fire, two blocked timesteps, fire again.
    pulse_clear();
    zero_cur();
    cur[0] = 25'd5000;
    run_frame(N, 1'b0, 1'b0);
    check("refr t1 bundle", bundle_a, 24'h000001);
    run_frame(N, 1'b0, 1'b0);
    check("refr t2 bundle", bundle_a, 24'h000000);
    check("refr t2 V0", dut.r_v[0], 26'd0);
    run_frame(N, 1'b0, 1'b0);
    check("refr t3 bundle", bundle_a, 24'h000000);
    run_frame(N, 1'b0, 1'b0);
    check("refr t4 bundle", bundle_a, 24'h000001);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
